// File: rtl/c499_key_loader_pkg.sv
// Shared constants, state encoding and CRC-8 step function for the c499 key loader.
// The CRC path is only built when LOADER_CRC_EN is defined.
package c499_key_pkg;

    localparam int KEY_W    = 18;
    localparam int P_W      = 4;
    localparam int X_W      = 14;
    localparam int CRC_W    = 8;
    localparam int CNT_W    = 5;
    localparam int MAX_FAIL = 3;

    localparam logic [KEY_W-1:0] DECOY     = 18'h2A5C3;
    localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CRC     = 3'd2,
        CHECK   = 3'd3,
        COMMIT  = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    // One serial step of CRC-8, MSB-first feedback.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc_in,
                                                   input logic             bit_in);
        logic fb;
        fb = crc_in[CRC_W-1] ^ bit_in;
        return {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
    endfunction

endpackage

// File: rtl/c499_key_loader_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00) over the incoming key bits.
// clr has priority over en.
module crc8_serial
    import c499_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/c499_key_loader.sv
// Serial key loader for the locked c499 core: shadow-shifts an 18-bit key and commits it atomically.
// Define LOADER_CRC_EN to append an 8-bit CRC check with fail counting and permanent lockout.
module c499_key_loader
    import c499_key_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic           sdi,
    input  logic           sdi_valid,
    output logic           sdi_ready,
    input  logic           key_clear,
    output logic [P_W-1:0] p_out,
    output logic [X_W-1:0] x_out,
    output logic           key_ok,
    output logic           busy,
    output logic           lockout,
    output logic [1:0]     fail_cnt
);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_ok_q, key_ok_d;
    logic               accept;

`ifdef LOADER_CRC_EN
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

    logic [CRC_W-1:0]   rx_crc_q, rx_crc_d;
    logic [1:0]         fail_q, fail_d;
    logic [1:0]         fail_inc;
    logic [CRC_W-1:0]   crc_val;
    logic               crc_clr;
    logic               crc_en;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (sdi),
        .crc    (crc_val)
    );

    assign fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
`endif

    assign sdi_ready = (state_q == SHIFT) || (state_q == CRC);
    assign accept    = sdi_valid && sdi_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        key_ok_d = key_ok_q;
`ifdef LOADER_CRC_EN
        rx_crc_d = rx_crc_q;
        fail_d   = fail_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
`endif
        // A clear beats every other action, including a pending commit.
        if (key_clear && (state_q != LOCKOUT)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            shadow_d = '0;
            key_d    = DECOY;
            key_ok_d = 1'b0;
`ifdef LOADER_CRC_EN
            crc_clr  = 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d  = SHIFT;
                        cnt_d    = '0;
                        shadow_d = '0;
`ifdef LOADER_CRC_EN
                        rx_crc_d = '0;
                        crc_clr  = 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shadow_d[cnt_q] = sdi;
`ifdef LOADER_CRC_EN
                        crc_en = 1'b1;
`endif
                        if (cnt_q == KEY_LAST) begin
                            cnt_d = '0;
`ifdef LOADER_CRC_EN
                            state_d = CRC;
`else
                            state_d = COMMIT;
`endif
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
`ifdef LOADER_CRC_EN
                CRC: begin
                    if (accept) begin
                        rx_crc_d = {rx_crc_q[CRC_W-2:0], sdi};
                        if (cnt_q == CRC_LAST) begin
                            cnt_d   = '0;
                            state_d = CHECK;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                CHECK: begin
                    if (rx_crc_q == crc_val) begin
                        state_d = COMMIT;
                    end else begin
                        fail_d   = fail_inc;
                        key_d    = DECOY;
                        key_ok_d = 1'b0;
                        state_d  = (fail_inc == 2'(MAX_FAIL)) ? LOCKOUT : IDLE;
                    end
                end
                LOCKOUT: begin
                    key_d    = DECOY;
                    key_ok_d = 1'b0;
                end
`endif
                COMMIT: begin
                    key_d    = shadow_q;
                    key_ok_d = 1'b1;
`ifdef LOADER_CRC_EN
                    fail_d   = 2'd0;
`endif
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            key_q    <= DECOY;
            key_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            key_ok_q <= key_ok_d;
        end
    end

`ifdef LOADER_CRC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_crc_q <= '0;
            fail_q   <= 2'd0;
        end else begin
            rx_crc_q <= rx_crc_d;
            fail_q   <= fail_d;
        end
    end

    assign fail_cnt = fail_q;
    assign lockout  = (state_q == LOCKOUT);
`else
    assign fail_cnt = 2'd0;
    assign lockout  = 1'b0;
`endif

    // key_q only ever holds DECOY or a committed key, so the shadow never leaks out.
    assign {x_out, p_out} = key_q;
    assign key_ok         = key_ok_q;
    assign busy           = (state_q != IDLE) && (state_q != LOCKOUT);

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed self-checking bench for c499_key_loader; follows LOADER_CRC_EN to choose the frame format.
module tb_c499_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        sdi = 1'b0;
    logic        sdi_valid = 1'b0;
    logic        key_clear = 1'b0;
    logic        sdi_ready;
    logic [3:0]  p_out;
    logic [13:0] x_out;
    logic        key_ok;
    logic        busy;
    logic        lockout;
    logic [1:0]  fail_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] DECOY_EXP = 18'h2A5C3;
`ifdef LOADER_CRC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    c499_key_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .sdi_ready  (sdi_ready),
        .key_clear  (key_clear),
        .p_out      (p_out),
        .x_out      (x_out),
        .key_ok     (key_ok),
        .busy       (busy),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef LOADER_CRC_EN
    function automatic logic [7:0] crc_ref(input logic [17:0] k);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 18; i++) begin
            fb = c[7] ^ k[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    // Entered and left at a negedge; the bit is taken on the posedge in between.
    task automatic send_bit(input logic b, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) begin
            sdi_valid = 1'b0;
            if ($urandom_range(1) == 1) @(negedge clk);
        end
        sdi       = b;
        sdi_valid = 1'b1;
        while (!sdi_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sdi_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_bit_ready: sdi_ready=%b required 1", sdi_ready);
        end
        @(negedge clk);
        sdi_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [17:0] key, input bit gaps, input int restart_at);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == restart_at) load_start = 1'b1;
            send_bit(key[i], gaps);
            load_start = 1'b0;
        end
`ifdef LOADER_CRC_EN
        begin
            logic [7:0] c;
            c = crc_ref(key);
            for (int j = 7; j >= 0; j--) send_bit(c[j], gaps);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL reset_key_ok: got %b want 0", key_ok); end
        checks++; if ({x_out, p_out} !== DECOY_EXP) begin errors++; $display("FAIL reset_key: got %h want %h", {x_out, p_out}, DECOY_EXP); end
        checks++; if (sdi_ready !== 1'b0) begin errors++; $display("FAIL reset_sdi_ready: got %b want 0", sdi_ready); end
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b want 0", lockout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
        $display("reset: key=%h key_ok=%b", {x_out, p_out}, key_ok);
    endtask

    task automatic test_zero_key();
        load_frame(18'h00000, 1'b0, -1);
        checks++; if (sdi_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_after_last: got %b want 0", sdi_ready); end
        repeat (LAT - 1) @(negedge clk);
        checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL zero_early_key_ok: got %b want 0", key_ok); end
        checks++; if ({x_out, p_out} !== DECOY_EXP) begin errors++; $display("FAIL zero_early_key: got %h want %h", {x_out, p_out}, DECOY_EXP); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (key_ok !== 1'b1) begin errors++; $display("FAIL zero_key_ok: got %b want 1", key_ok); end
        checks++; if ({x_out, p_out} !== 18'h00000) begin errors++; $display("FAIL zero_key: got %h want 00000", {x_out, p_out}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle: busy=%b want 0", busy); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL zero_fail_cnt: got %0d want 0", fail_cnt); end
        $display("zero_key: key=%h key_ok=%b", {x_out, p_out}, key_ok);
    endtask

    task automatic test_clear_mid_shift();
        load_frame(18'h3FFFF, 1'b0, -1);
        repeat (LAT) @(negedge clk);
        checks++; if ({x_out, p_out} !== 18'h3FFFF) begin errors++; $display("FAIL clear_commit: got %h want 3ffff", {x_out, p_out}); end
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0);
        checks++; if ({x_out, p_out} !== 18'h3FFFF) begin errors++; $display("FAIL clear_hold_old: got %h want 3ffff", {x_out, p_out}); end
        key_clear = 1'b1;
        sdi       = 1'b1;
        sdi_valid = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
        sdi_valid = 1'b0;
        checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL clear_key_ok: got %b want 0", key_ok); end
        checks++; if ({x_out, p_out} !== DECOY_EXP) begin errors++; $display("FAIL clear_key: got %h want %h", {x_out, p_out}, DECOY_EXP); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_idle: busy=%b want 0", busy); end
        checks++; if (sdi_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b want 0", sdi_ready); end
        repeat (4) @(negedge clk);
        checks++; if ({x_out, p_out} !== DECOY_EXP) begin errors++; $display("FAIL clear_stays: got %h want %h", {x_out, p_out}, DECOY_EXP); end
        $display("clear_mid_shift: key=%h key_ok=%b", {x_out, p_out}, key_ok);
    endtask

    task automatic test_gaps();
        load_frame(18'h15A3C, 1'b1, -1);
        repeat (LAT) @(negedge clk);
        checks++; if (p_out !== 4'hC) begin errors++; $display("FAIL gaps_p_out: got %h want c", p_out); end
        checks++; if (x_out !== 14'h15A3) begin errors++; $display("FAIL gaps_x_out: got %h want 15a3", x_out); end
        checks++; if (key_ok !== 1'b1) begin errors++; $display("FAIL gaps_key_ok: got %b want 1", key_ok); end
        $display("gaps: p=%h x=%h key_ok=%b", p_out, x_out, key_ok);
    endtask

    task automatic test_back_to_back();
        load_frame(18'h2B7D1, 1'b0, -1);
        repeat (LAT) @(negedge clk);
        checks++; if ({x_out, p_out} !== 18'h2B7D1) begin errors++; $display("FAIL b2b_first: got %h want 2b7d1", {x_out, p_out}); end
        load_frame(18'h0F0F0, 1'b0, 5);
        repeat (LAT - 1) @(negedge clk);
        checks++; if ({x_out, p_out} !== 18'h2B7D1) begin errors++; $display("FAIL b2b_undisturbed: got %h want 2b7d1", {x_out, p_out}); end
        checks++; if (key_ok !== 1'b1) begin errors++; $display("FAIL b2b_key_ok_hold: got %b want 1", key_ok); end
        @(negedge clk);
        checks++; if ({x_out, p_out} !== 18'h0F0F0) begin errors++; $display("FAIL b2b_second: got %h want 0f0f0", {x_out, p_out}); end
        $display("back_to_back: key=%h key_ok=%b", {x_out, p_out}, key_ok);
    endtask

`ifdef LOADER_CRC_EN
    task automatic test_crc_lockout();
        bit saw_ready;
        for (int n = 1; n <= 3; n++) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
            for (int i = 0; i < 18; i++) send_bit(1'b0, 1'b0);
            for (int j = 7; j >= 0; j--) send_bit((j == 0), 1'b0);
            @(negedge clk);
            checks++; if (fail_cnt !== 2'(n)) begin errors++; $display("FAIL lock_fail_cnt%0d: got %0d want %0d", n, fail_cnt, n); end
            checks++; if (lockout !== (n == 3)) begin errors++; $display("FAIL lock_lockout%0d: got %b want %b", n, lockout, (n == 3)); end
            checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL lock_key_ok%0d: got %b want 0", n, key_ok); end
            checks++; if ({x_out, p_out} !== DECOY_EXP) begin errors++; $display("FAIL lock_key%0d: got %h want %h", n, {x_out, p_out}, DECOY_EXP); end
            $display("crc_fail %0d: fail_cnt=%0d lockout=%b", n, fail_cnt, lockout);
        end
        saw_ready  = 1'b0;
        load_start = 1'b1;
        sdi_valid  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            key_clear = (c == 10);
            @(negedge clk);
            if (sdi_ready) saw_ready = 1'b1;
        end
        load_start = 1'b0;
        sdi_valid  = 1'b0;
        key_clear  = 1'b0;
        checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL lock_no_ready: saw=%b want 0", saw_ready); end
        checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b want 1", lockout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy: got %b want 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lock_rst_lockout: got %b want 0", lockout); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lock_rst_fail_cnt: got %0d want 0", fail_cnt); end
        load_frame(18'h00001, 1'b0, -1);
        repeat (LAT) @(negedge clk);
        checks++; if ({x_out, p_out} !== 18'h00001) begin errors++; $display("FAIL lock_recover_key: got %h want 00001", {x_out, p_out}); end
        $display("lockout: recovered key=%h key_ok=%b", {x_out, p_out}, key_ok);
    endtask
`else
    task automatic test_no_crc();
        load_frame(18'h00001, 1'b0, -1);
        checks++; if (sdi_ready !== 1'b0) begin errors++; $display("FAIL nocrc_ready: got %b want 0", sdi_ready); end
        @(negedge clk);
        checks++; if (p_out !== 4'h1) begin errors++; $display("FAIL nocrc_p_out: got %h want 1", p_out); end
        checks++; if (x_out !== 14'h0000) begin errors++; $display("FAIL nocrc_x_out: got %h want 0", x_out); end
        checks++; if (key_ok !== 1'b1) begin errors++; $display("FAIL nocrc_key_ok: got %b want 1", key_ok); end
        checks++; if (sdi_ready !== 1'b0) begin errors++; $display("FAIL nocrc_ready_idle: got %b want 0", sdi_ready); end
        $display("no_crc: p=%h x=%h key_ok=%b", p_out, x_out, key_ok);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_key();
        test_clear_mid_shift();
        test_gaps();
        test_back_to_back();
`ifdef LOADER_CRC_EN
        test_crc_lockout();
`else
        test_no_crc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c499_key_loader.md
Name: c499_key_loader

Overview:
- Upstream stage of the locked c499 instance. Serially receives the 18-bit unlock key: 4 mux-select bits p1..p4 and 14 XOR key bits X_1..X_14.
- Holds the key in a shadow register and commits it atomically to the key outputs, which drive the locked core's key inputs.
- Until a valid key is committed, or after a clear or lockout, the outputs carry a fixed decoy key, never a partial key.

Parameters:
- KEY_W, 18, total key bits (P_W + X_W).
- P_W, 4, mux-select key bits.
- X_W, 14, XOR key bits.
- MAX_FAIL, 3, failed checks before permanent lockout (1..3).
- DECOY, 18'h2A5C3, value driven on the key outputs while no key is committed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  begin a key load; honoured only in IDLE.
- sdi  in  1  serial key/CRC data bit.
- sdi_valid  in  1  sdi carries a bit.
- sdi_ready  out  1  loader accepts a bit this cycle.
- key_clear  in  1  wipe the committed key and abort any load.
- p_out  out  4  to p1..p4; p_out[0]=p1.
- x_out  out  14  to X_1..X_14; x_out[0]=X_1.
- key_ok  out  1  committed key is driving the outputs.
- busy  out  1  a load is in progress.
- lockout  out  1  permanent lockout until rst.
- fail_cnt  out  2  saturating count of consecutive failed checks.

Behaviour:
- Reset (async, active-high) gives:
  - state=IDLE; sdi_ready=0; busy=0; key_ok=0; lockout=0; fail_cnt=0.
  - {x_out,p_out}=DECOY; shadow register and bit counter cleared.
- States: IDLE, SHIFT, CRC, CHECK, COMMIT, LOCKOUT.
- Handshake: a bit is accepted on an edge where sdi_valid && sdi_ready. sdi_ready=1 only in SHIFT and CRC.
- Bit order: the i-th accepted key bit goes to shadow[i]. shadow[3:0] maps to p, shadow[17:4] maps to x.
- IDLE: load_start -> SHIFT; counter=0, shadow=0, CRC=0. busy=1 in every state except IDLE and LOCKOUT.
- SHIFT: on the KEY_W-th accepted bit -> CRC (with the macro) or -> COMMIT (without it).
- CRC: accepts 8 bits, MSB first; after the 8th accepted bit -> CHECK.
- CHECK: one cycle.
  - Match: -> COMMIT.
  - Mismatch: fail_cnt++ (saturating), key_ok=0, outputs=DECOY.
  - If the new fail_cnt equals MAX_FAIL -> LOCKOUT, else -> IDLE.
- COMMIT: one cycle. At its exit edge, key register <= shadow, key_ok=1, fail_cnt=0, -> IDLE.
- Latency: outputs change on the edge two cycles after the final accepted bit.
- Key outputs = key_ok ? key_reg : DECOY. They are registered, glitch-free, and never show shadow contents.
- load_start outside IDLE is ignored.
- A stalled sdi_valid holds state indefinitely. There is no timeout.
- A new load does not disturb the committed key until its own COMMIT.
- key_clear:
  - Honoured in every state except LOCKOUT.
  - Has priority over load_start, data and COMMIT.
  - Next edge: key_ok=0, outputs=DECOY, shadow=0, -> IDLE. fail_cnt is unchanged.
- LOCKOUT: lockout=1, sdi_ready=0, key_ok=0, outputs=DECOY. All inputs are ignored; only rst exits.
- CRC-8:
  - poly 0x07, init 0x00, computed over the key bits in arrival order.
  - Per bit: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).

Optional Feature:
- LOADER_CRC_EN defined: the CRC and CHECK states exist; failures count and lockout is reachable.
- LOADER_CRC_EN undefined: SHIFT goes directly to COMMIT. No CRC bits are received. fail_cnt and lockout are tied to 0, and the CRC logic is absent.

Decomposition:
- Package c499_key_pkg holds:
  - KEY_W, P_W, X_W, DECOY.
  - CRC8_POLY = 8'h07.
  - The state enum type.
- One sub-module: crc8_serial (clk, rst, clr, en, bit_in, crc[7:0]), instantiated only under LOADER_CRC_EN.

Test Plan:
- Reset, then idle for 10 cycles -> key_ok=0, {x_out,p_out}=18'h2A5C3, sdi_ready=0, lockout=0.
- CRC_EN, load 18 zero bits plus CRC 8'h00 with continuous valid -> key_ok=1 and outputs=0 exactly 2 cycles after the last bit; fail_cnt=0.
- CRC_EN, 18 zeros plus CRC 8'h01, repeated 3 times -> fail_cnt 1, then 2, then lockout=1. A further load_start with a correct frame gives no sdi_ready; only rst recovers.
- Commit key 18'h3FFFF, then start a new load and assert key_clear mid-SHIFT (bit 9) -> next edge: outputs=DECOY, key_ok=0, state IDLE.
- Random sdi_valid gaps (50% duty) loading key 18'h15A3C (checked against a reference CRC model) -> exact bit mapping: p_out=4'hC, x_out=14'h15A3, key_ok=1.
- CRC_EN undefined: 18 bits of 18'h00001 -> p_out=4'h1, x_out=0, key_ok=1. No CRC bits are consumed; sdi_ready=0 after the 18th bit.
